// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified memory port arbiter:
// FSM state encoding, access size codes and lane mask / alignment helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_IF = 2'd1,
    ST_WAIT_LS = 2'd2,
    ST_ERR     = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Byte enables for an access of 2**size bytes starting at byte lane offset.
  function automatic logic [7:0] size_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [15:0] m;
    m = ((16'd1 << (4'd1 << size)) - 16'd1) << offset;
    return m[7:0];
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
    logic [3:0] low_bits;
    low_bits = (4'd1 << size) - 4'd1;
    return (({1'b0, offset} & low_bits) != 4'd0);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational byte-lane alignment between the requesters and the 64-bit
// memory port: store shift and byte mask, load right-shift, fetch half select.
module mem_port_arbiter_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [63:0] ls_wdata_i,
  input  logic [2:0]  ls_off_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_we_i,
  input  logic [2:0]  rd_off_i,
  input  logic        if_hi_i,
  input  logic [63:0] mem_rdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wmask_o,
  output logic [63:0] ls_rdata_o,
  output logic [31:0] if_rdata_o
);

  logic [5:0] wr_shift;
  logic [5:0] rd_shift;

  assign wr_shift   = {ls_off_i, 3'b000};
  assign rd_shift   = {rd_off_i, 3'b000};

  assign wdata_o    = ls_wdata_i << wr_shift;
  // Loads never enable byte lanes; only stores write.
  assign wmask_o    = ls_we_i ? size_mask(ls_size_i, ls_off_i) : 8'h00;
  assign ls_rdata_o = mem_rdata_i >> rd_shift;
  assign if_rdata_o = if_hi_i ? mem_rdata_i[63:32] : mem_rdata_i[31:0];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// LS has priority; a streak limit forces one IF grant after MAX_LS_STREAK LS grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [1:0]        ls_size_i,
  input  logic [63:0]       ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [63:0]       ls_rdata_o,
  output logic              ls_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic [7:0]        mem_wmask_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i
);

  localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
  localparam logic [ADDR_W-1:0]   LANE_CLR   = ~ADDR_W'(7);

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [2:0]          off_q, off_d;
  logic                we_q, we_d;
  logic                if_hi_q, if_hi_d;

  logic        ls_win;
  logic        ls_mis;
  logic        ls_take;
  logic [63:0] al_wdata;
  logic [7:0]  al_wmask;
  logic [63:0] al_ls_rdata;
  logic [31:0] al_if_rdata;

  assign ls_win = ls_req_i && !(if_req_i && (streak_q == STREAK_MAX));
  assign ls_mis = misaligned(ls_size_i, ls_addr_i[2:0]);

  mem_port_arbiter_lane_align u_align (
    .ls_wdata_i  (ls_wdata_i),
    .ls_off_i    (ls_addr_i[2:0]),
    .ls_size_i   (ls_size_i),
    .ls_we_i     (ls_we_i),
    .rd_off_i    (off_q),
    .if_hi_i     (if_hi_q),
    .mem_rdata_i (mem_rdata_i),
    .wdata_o     (al_wdata),
    .wmask_o     (al_wmask),
    .ls_rdata_o  (al_ls_rdata),
    .if_rdata_o  (al_if_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      streak_q <= '0;
      off_q    <= '0;
      we_q     <= 1'b0;
      if_hi_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      off_q    <= off_d;
      we_q     <= we_d;
      if_hi_q  <= if_hi_d;
    end
  end

  // Every output is qualified by rst_ni so the port is silent while reset is held.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    off_d       = off_q;
    we_d        = we_q;
    if_hi_d     = if_hi_q;
    ls_take     = 1'b0;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_gnt_o    = 1'b0;
    ls_rvalid_o = 1'b0;
    ls_rdata_o  = '0;
    ls_err_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rst_ni && ls_win) begin
          if (ls_mis) begin
            // Misaligned accesses never reach memory; answered from ERR.
            ls_take = 1'b1;
            state_d = ST_ERR;
          end else begin
            mem_req_o   = 1'b1;
            mem_we_o    = ls_we_i;
            mem_addr_o  = ls_addr_i & LANE_CLR;
            mem_wdata_o = al_wdata;
            mem_wmask_o = al_wmask;
            ls_take     = mem_gnt_i;
            if (mem_gnt_i) begin
              state_d = ST_WAIT_LS;
              off_d   = ls_addr_i[2:0];
              we_d    = ls_we_i;
            end
          end
          ls_gnt_o = ls_take;
          if (ls_take) begin
            if (!if_req_i) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end
        end else if (rst_ni && if_req_i) begin
          mem_req_o  = 1'b1;
          mem_addr_o = if_addr_i & LANE_CLR;
          if_gnt_o   = mem_gnt_i;
          if (mem_gnt_i) begin
            state_d  = ST_WAIT_IF;
            if_hi_d  = if_addr_i[2];
            streak_d = '0;
          end
        end
      end

      ST_WAIT_IF: begin
        if (rst_ni && mem_rvalid_i) begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = al_if_rdata;
          state_d     = ST_IDLE;
        end
      end

      ST_WAIT_LS: begin
        if (rst_ni && mem_rvalid_i) begin
          ls_rvalid_o = 1'b1;
          ls_rdata_o  = we_q ? 64'd0 : al_ls_rdata;
          state_d     = ST_IDLE;
        end
      end

      ST_ERR: begin
        if (rst_ni) begin
          ls_rvalid_o = 1'b1;
          ls_err_o    = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
